// File: rtl/coin_acceptor.sv
// Coin acceptor: syncs and debounces nickel/dime sensors, emits one-cycle N/D/reject pulses, flags jams.
// Latency: N/D/reject rise on the (DEB_CYCLES+3)th edge after the raw sensor is first sampled high.
// Backpressure: none; the debounce spacing bounds event rate so one pending flag per channel suffices.
module coin_acceptor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 3,
    parameter int JAM_CYCLES = 64,
    parameter int JAM_W      = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic nsw,
    input  logic dsw,
    input  logic inhibit,
    output logic N,
    output logic D,
    output logic reject,
    output logic jam
);

    // Channel index 0 is the nickel sensor, index 1 the dime sensor.
    logic [1:0]       sync1;
    logic [1:0]       sync2;
    logic [1:0]       deb;
    logic [CNT_W-1:0] dcnt [2];
    logic [JAM_W-1:0] jcnt [2];
    logic [1:0]       flip;
    logic [1:0]       rise;
    logic [1:0]       jam_hit;
    logic             refuse;
    logic             nick_pend;
    logic             dime_pend;
    logic             rej_pend;

    always_comb begin
        flip    = 2'b00;
        rise    = 2'b00;
        jam_hit = 2'b00;
        for (int i = 0; i < 2; i++) begin
            flip[i]    = (sync2[i] != deb[i]) && (dcnt[i] == CNT_W'(DEB_CYCLES - 1));
            rise[i]    = flip[i] && !deb[i];
            jam_hit[i] = deb[i] && (jcnt[i] == JAM_W'(JAM_CYCLES - 1));
        end
        refuse = inhibit || jam;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1     <= '0;
            sync2     <= '0;
            deb       <= '0;
            for (int i = 0; i < 2; i++) begin
                dcnt[i] <= '0;
                jcnt[i] <= '0;
            end
            nick_pend <= 1'b0;
            dime_pend <= 1'b0;
            rej_pend  <= 1'b0;
            N         <= 1'b0;
            D         <= 1'b0;
            reject    <= 1'b0;
            jam       <= 1'b0;
        end else begin
            sync1 <= {dsw, nsw};
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    dcnt[i] <= '0;
                end else if (flip[i]) begin
                    dcnt[i] <= '0;
                    deb[i]  <= ~deb[i];
                end else begin
                    dcnt[i] <= dcnt[i] + 1'b1;
                end
                // Saturate so a sensor held high for hours cannot wrap the counter.
                if (!deb[i])
                    jcnt[i] <= '0;
                else if (jcnt[i] != JAM_W'(JAM_CYCLES))
                    jcnt[i] <= jcnt[i] + 1'b1;
            end
            if (|jam_hit)
                jam <= 1'b1;

            // Acceptance uses the jam/inhibit state seen in the event cycle.
            rej_pend  <= refuse && (|rise);
            dime_pend <= rise[1] && !refuse;
            if (rise[0] && !refuse)
                nick_pend <= 1'b1;
            else if (!dime_pend)
                nick_pend <= 1'b0;

            reject <= rej_pend;
            D      <= dime_pend;
            N      <= nick_pend && !dime_pend;
        end
    end

endmodule

// File: tb/tb_coin_acceptor.sv
// Randomised and directed bench for coin_acceptor against a cycle-indexed schedule of expected pulses.
module tb_coin_acceptor;

    localparam int DEB = 4;
    localparam int JAM = 64;
    localparam int SZ  = 16384;

    logic clk = 1'b0;
    logic reset;
    logic nsw, dsw, inhibit;
    logic N, D, reject, jam;

    int checks = 0;
    int fails  = 0;

    coin_acceptor #(.DEB_CYCLES(DEB), .CNT_W(3), .JAM_CYCLES(JAM), .JAM_W(7)) dut (
        .clk(clk), .reset(reset), .nsw(nsw), .dsw(dsw), .inhibit(inhibit),
        .N(N), .D(D), .reject(reject), .jam(jam)
    );

    always #5 clk = ~clk;

    // Reference model: per-channel run lengths and a timeline of expected pulses indexed by edge number.
    int cyc = 0;
    bit exp_n [0:SZ-1];
    bit exp_d [0:SZ-1];
    bit exp_r [0:SZ-1];
    bit r1 [2];
    bit r2 [2];
    bit mdeb [2];
    int run [2];
    int jrun [2];
    bit mjam = 1'b0;

    task automatic model_clear_state();
        for (int c = 0; c < 2; c++) begin
            r1[c] = 0; r2[c] = 0; mdeb[c] = 0; run[c] = 0; jrun[c] = 0;
        end
        mjam = 0;
    endtask

    always @(negedge reset) begin
        model_clear_state();
        for (int i = cyc; i < SZ; i++) begin
            exp_n[i] = 0; exp_d[i] = 0; exp_r[i] = 0;
        end
    end

    always @(posedge clk) begin
        bit raw [2];
        bit rise [2];
        bit lvl;
        bit old_jam;
        cyc++;
        if (!reset) begin
            model_clear_state();
        end else begin
            raw[0] = nsw; raw[1] = dsw;
            old_jam = mjam;
            for (int c = 0; c < 2; c++) begin
                rise[c] = 0;
                if (mdeb[c]) begin
                    if (jrun[c] < JAM) jrun[c]++;
                    if (jrun[c] == JAM) mjam = 1;
                end else begin
                    jrun[c] = 0;
                end
                lvl = r2[c];
                r2[c] = r1[c];
                r1[c] = raw[c];
                if (lvl != mdeb[c]) begin
                    run[c]++;
                    if (run[c] == DEB) begin
                        mdeb[c] = lvl;
                        run[c]  = 0;
                        rise[c] = lvl;
                    end
                end else begin
                    run[c] = 0;
                end
            end
            if (rise[0] || rise[1]) begin
                if (inhibit || old_jam) begin
                    exp_r[cyc+1] = 1;
                end else begin
                    if (rise[1]) exp_d[cyc+1] = 1;
                    if (rise[0]) exp_n[cyc + 1 + int'(rise[1])] = 1;
                end
            end
        end
    end

    // Observer: tallies pulses and cycle-level divergence from the model, sampled mid-cycle.
    int obs_n = 0, obs_d = 0, obs_r = 0, en = 0, ed = 0, er = 0;
    int last_n = -1, last_d = -1, last_r = -1, jam_first = -1;
    int div = 0, overlap = 0;

    always @(negedge clk) begin
        if (N !== exp_n[cyc] || D !== exp_d[cyc] || reject !== exp_r[cyc] || jam !== mjam) div++;
        if (N === 1'b1) begin obs_n++; last_n = cyc; end
        if (D === 1'b1) begin obs_d++; last_d = cyc; end
        if (reject === 1'b1) begin obs_r++; last_r = cyc; end
        if (exp_n[cyc]) en++;
        if (exp_d[cyc]) ed++;
        if (exp_r[cyc]) er++;
        if (N === 1'b1 && D === 1'b1) overlap++;
        if (jam === 1'b1 && jam_first < 0) jam_first = cyc;
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 0; nsw = 0; dsw = 0; inhibit = 0;
        cycles(3);
        checks++; if (N !== 1'b0) begin fails++; $display("FAIL reset_N: got %b want 0", N); end
        checks++; if (D !== 1'b0) begin fails++; $display("FAIL reset_D: got %b want 0", D); end
        checks++; if (reject !== 1'b0) begin fails++; $display("FAIL reset_reject: got %b want 0", reject); end
        checks++; if (jam !== 1'b0) begin fails++; $display("FAIL reset_jam: got %b want 0", jam); end
        reset = 1;
        cycles(3);
    endtask

    task automatic test_clean_nickel();
        int n0 = obs_n, d0 = obs_d, r0 = obs_r, v0 = div, e1;
        e1 = cyc + 1;
        nsw = 1;
        cycles(10);
        nsw = 0;
        cycles(12);
        checks++; if (obs_n - n0 !== 1) begin fails++; $display("FAIL nickel_count: got %0d want 1", obs_n - n0); end
        checks++; if (last_n !== e1 + 6) begin fails++; $display("FAIL nickel_latency: got edge %0d want %0d", last_n, e1 + 6); end
        checks++; if (obs_d - d0 !== 0 || obs_r - r0 !== 0) begin fails++; $display("FAIL nickel_quiet: D %0d reject %0d want 0", obs_d - d0, obs_r - r0); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL nickel_model: %0d divergent cycles want 0", div - v0); end
    endtask

    task automatic test_bounce_dime();
        bit pat [6] = '{1, 0, 1, 1, 0, 1};
        int n0 = obs_n, d0 = obs_d, v0 = div, es = 0;
        for (int i = 0; i < 6; i++) begin
            dsw = pat[i];
            if (i == 5) es = cyc + 1;
            @(negedge clk);
        end
        cycles(8);
        dsw = 0;
        cycles(12);
        checks++; if (obs_d - d0 !== 1) begin fails++; $display("FAIL bounce_count: got %0d want 1", obs_d - d0); end
        checks++; if (last_d !== es + 6) begin fails++; $display("FAIL bounce_latency: got edge %0d want %0d", last_d, es + 6); end
        checks++; if (obs_n - n0 !== 0) begin fails++; $display("FAIL bounce_noN: got %0d want 0", obs_n - n0); end
        d0 = obs_d;
        dsw = 1;
        cycles(3);
        dsw = 0;
        cycles(12);
        checks++; if (obs_d - d0 !== 0) begin fails++; $display("FAIL glitch_noD: got %0d want 0", obs_d - d0); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL bounce_model: %0d divergent cycles want 0", div - v0); end
    endtask

    task automatic test_simultaneous();
        int n0 = obs_n, d0 = obs_d, o0 = overlap, v0 = div, e1;
        e1 = cyc + 1;
        nsw = 1; dsw = 1;
        cycles(10);
        nsw = 0; dsw = 0;
        cycles(12);
        checks++; if (obs_d - d0 !== 1 || obs_n - n0 !== 1) begin fails++; $display("FAIL simul_count: D %0d N %0d want 1 1", obs_d - d0, obs_n - n0); end
        checks++; if (last_d !== e1 + 6) begin fails++; $display("FAIL simul_D_edge: got %0d want %0d", last_d, e1 + 6); end
        checks++; if (last_n !== e1 + 7) begin fails++; $display("FAIL simul_N_edge: got %0d want %0d", last_n, e1 + 7); end
        checks++; if (overlap - o0 !== 0) begin fails++; $display("FAIL simul_overlap: got %0d want 0", overlap - o0); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL simul_model: %0d divergent cycles want 0", div - v0); end
    endtask

    task automatic test_inhibit();
        int n0 = obs_n, r0 = obs_r, v0 = div, e1;
        inhibit = 1;
        e1 = cyc + 1;
        nsw = 1;
        cycles(10);
        nsw = 0;
        cycles(12);
        inhibit = 0;
        checks++; if (obs_r - r0 !== 1) begin fails++; $display("FAIL inhibit_reject_count: got %0d want 1", obs_r - r0); end
        checks++; if (last_r !== e1 + 6) begin fails++; $display("FAIL inhibit_reject_edge: got %0d want %0d", last_r, e1 + 6); end
        checks++; if (obs_n - n0 !== 0) begin fails++; $display("FAIL inhibit_noN: got %0d want 0", obs_n - n0); end
        n0 = obs_n; r0 = obs_r;
        e1 = cyc + 1;
        nsw = 1;
        cycles(10);
        nsw = 0;
        cycles(12);
        checks++; if (obs_n - n0 !== 1 || last_n !== e1 + 6) begin fails++; $display("FAIL uninhibit_N: count %0d edge %0d want 1 at %0d", obs_n - n0, last_n, e1 + 6); end
        checks++; if (obs_r - r0 !== 0) begin fails++; $display("FAIL uninhibit_noreject: got %0d want 0", obs_r - r0); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL inhibit_model: %0d divergent cycles want 0", div - v0); end
    endtask

    task automatic test_jam();
        int n0 = obs_n, d0, r0, v0 = div, e1;
        jam_first = -1;
        e1 = cyc + 1;
        nsw = 1;
        cycles(80);
        nsw = 0;
        cycles(12);
        checks++; if (obs_n - n0 !== 1) begin fails++; $display("FAIL jam_one_N: got %0d want 1", obs_n - n0); end
        checks++; if (jam_first !== e1 + 69) begin fails++; $display("FAIL jam_edge: got %0d want %0d", jam_first, e1 + 69); end
        d0 = obs_d; r0 = obs_r;
        e1 = cyc + 1;
        dsw = 1;
        cycles(10);
        dsw = 0;
        cycles(12);
        checks++; if (obs_r - r0 !== 1 || last_r !== e1 + 6) begin fails++; $display("FAIL jam_reject: count %0d edge %0d want 1 at %0d", obs_r - r0, last_r, e1 + 6); end
        checks++; if (obs_d - d0 !== 0) begin fails++; $display("FAIL jam_noD: got %0d want 0", obs_d - d0); end
        checks++; if (jam !== 1'b1) begin fails++; $display("FAIL jam_sticky: got %b want 1", jam); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL jam_model: %0d divergent cycles want 0", div - v0); end
        @(posedge clk);
        #1 reset = 0;
        #1;
        checks++; if (jam !== 1'b0) begin fails++; $display("FAIL jam_async_clear: got %b want 0", jam); end
        cycles(2);
        reset = 1;
        cycles(3);
    endtask

    task automatic test_reset_pending();
        int n0 = obs_n, d0 = obs_d, v0 = div, e1;
        e1 = cyc + 1;
        nsw = 1;
        while (cyc < e1 + 5) @(negedge clk);
        #1 reset = 0;
        nsw = 0;
        #1;
        checks++; if (N !== 1'b0 || D !== 1'b0 || reject !== 1'b0) begin fails++; $display("FAIL rstpend_outputs: N %b D %b reject %b want 0", N, D, reject); end
        cycles(3);
        reset = 1;
        cycles(20);
        checks++; if (obs_n - n0 !== 0 || obs_d - d0 !== 0) begin fails++; $display("FAIL rstpend_discard: N %0d D %0d want 0", obs_n - n0, obs_d - d0); end
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL rstpend_model: %0d divergent cycles want 0", div - v0); end
    endtask

    task automatic test_random();
        int n0 = obs_n, d0 = obs_d, r0 = obs_r, v0 = div, o0 = overlap;
        int en0 = en, ed0 = ed, er0 = er;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            nsw = 1'($urandom_range(0, 1));
            dsw = 1'($urandom_range(0, 1));
            inhibit = ($urandom_range(0, 5) == 0);
            cycles($urandom_range(1, 10));
        end
        nsw = 0; dsw = 0; inhibit = 0;
        cycles(15);
        checks++; if (div - v0 !== 0) begin fails++; $display("FAIL random_model: %0d divergent cycles want 0", div - v0); end
        checks++; if (obs_n - n0 !== en - en0) begin fails++; $display("FAIL random_N_count: got %0d want %0d", obs_n - n0, en - en0); end
        checks++; if (obs_d - d0 !== ed - ed0) begin fails++; $display("FAIL random_D_count: got %0d want %0d", obs_d - d0, ed - ed0); end
        checks++; if (obs_r - r0 !== er - er0) begin fails++; $display("FAIL random_reject_count: got %0d want %0d", obs_r - r0, er - er0); end
        checks++; if (overlap - o0 !== 0) begin fails++; $display("FAIL random_overlap: got %0d want 0", overlap - o0); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_clean_nickel();
        test_bounce_dime();
        test_simultaneous();
        test_inhibit();
        test_reset_pending();
        test_random();
        test_jam();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
Front-end coin acceptor that drives the N/D coin inputs of the vending-machine FSM. It synchronises and debounces two raw mechanical coin sensors and converts each validated coin into a single-cycle N or D pulse. N and D are never asserted together. It also rejects coins while the machine is inhibited and flags a jammed sensor.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles required before the debounced sensor level changes (>=2)
CNT_W, 3, width of the debounce counters; must hold DEB_CYCLES
JAM_CYCLES, 64, consecutive debounced-high cycles on one sensor that declare a jam
JAM_W, 7, width of the jam counters; must hold JAM_CYCLES

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
nsw  input  1  raw nickel sensor, active-high, asynchronous to clk, may bounce
dsw  input  1  raw dime sensor, active-high, asynchronous to clk, may bounce
inhibit  input  1  synchronous; 1 = machine not accepting coins (e.g. while dispensing)
N  output  1  one-cycle nickel pulse to the vending FSM
D  output  1  one-cycle dime pulse to the vending FSM
reject  output  1  one-cycle pulse: coin validated but refused, routed to return chute
jam  output  1  sticky jam flag

Behaviour:
- Reset (reset=0, asynchronous) clears synchronisers, debounced levels, counters, pending flags, N, D, reject and jam to 0. Deassertion takes effect at the next clk edge.
- Synchroniser: 2-flop chain per sensor. Nothing downstream sees raw inputs.
- Debounce, per channel:
  - The counter increments each cycle the synchronised level differs from the debounced level.
  - It clears on any cycle the two match.
  - When the count reaches DEB_CYCLES, the debounced level flips and the counter clears.
  - Glitches shorter than DEB_CYCLES never change the debounced level.
- Coin event: a rising edge of a debounced level (0->1) in a given cycle. Falling edges generate nothing.
- Acceptance, evaluated at the event cycle:
  - If inhibit=1 or jam=1, reject pulses for one cycle and no pending flag is set.
  - Otherwise the channel's pending flag is set.
  - If both channels are refused in the same cycle, reject is a single one-cycle pulse.
- Output arbiter (registered), each cycle:
  - If dime_pend is set: D=1 and dime_pend clears.
  - Else if nick_pend is set: N=1 and nick_pend clears.
  - Dime has priority. At most one of N/D is high per cycle.
  - Simultaneous events produce D then N on consecutive cycles.
- No overflow is possible: each channel needs at least 2*DEB_CYCLES cycles between rising edges, and a pending flag waits at most one cycle.
- Latency (uncontended): N/D rises on the (DEB_CYCLES+3)th rising clk edge, counting the first edge that samples the raw sensor high. Reject has the same latency. Pulse width is exactly 1 cycle.
- Jam:
  - A per-channel counter increments while the debounced level is 1 and clears while it is 0.
  - When either counter reaches JAM_CYCLES, jam=1. Jam is sticky and cleared only by reset.
  - Coins whose events are already pending at jam assertion are still delivered.
- Inhibit changes take effect on the event cycle only. Already-pending coins are delivered even if inhibit rises afterwards.
- Reset mid-operation discards pending coins. No pulse is emitted after reset release until a new full debounce completes.

Test Plan:
- DEB_CYCLES=4, clean nsw high for 10 cycles, inhibit=0 -> N=1 for exactly one cycle on the 7th edge after nsw rises; D, reject stay 0.
- dsw bounces (1,0,1,1,0,1 per cycle) then holds high 8 cycles -> exactly one D pulse, timed from the start of the stable run; 3-cycle glitch alone -> no pulse.
- nsw and dsw rise on the same edge -> D pulse on the 7th edge, N pulse on the 8th edge, never overlapping.
- inhibit=1 throughout a clean nickel insertion -> reject=1 for one cycle at the 7th edge, N=0. Repeat with inhibit=0 -> N pulse.
- nsw held high for 80 cycles (JAM_CYCLES=64) -> one N pulse, then jam=1 from about 67 cycles in. A subsequent dime -> reject, no D. jam stays 1 until reset=0.
- reset driven low one cycle after debounced nsw rises (pending set) -> outputs 0 immediately, asynchronously. After release, no N pulse without a new insertion.
